// File: rtl/ctrl_pkg.sv
// Shared constants and state encoding for the accumulator-processor control unit.
package ctrl_pkg;

    localparam logic [7:0] OpNop   = 8'h00;
    localparam logic [7:0] OpLdac  = 8'h01;
    localparam logic [7:0] OpStac  = 8'h02;
    localparam logic [7:0] OpMvac  = 8'h03;
    localparam logic [7:0] OpMvr   = 8'h04;
    localparam logic [7:0] OpAdd   = 8'h05;
    localparam logic [7:0] OpSub   = 8'h06;
    localparam logic [7:0] OpMul   = 8'h07;
    localparam logic [7:0] OpIncac = 8'h08;
    localparam logic [7:0] OpDecac = 8'h09;
    localparam logic [7:0] OpClac  = 8'h0A;
    localparam logic [7:0] OpLdi   = 8'h0B;
    localparam logic [7:0] OpJump  = 8'h0C;
    localparam logic [7:0] OpJmpn  = 8'h0D;
    localparam logic [7:0] OpEndop = 8'h0E;

    localparam logic [3:0] RegMdr     = 4'd0;
    localparam logic [3:0] RegL       = 4'd1;
    localparam logic [3:0] RegX       = 4'd2;
    localparam logic [3:0] RegCenterP = 4'd3;
    localparam logic [3:0] RegJ       = 4'd4;
    localparam logic [3:0] RegT       = 4'd5;
    localparam logic [3:0] RegH       = 4'd6;
    localparam logic [3:0] RegW       = 4'd7;
    localparam logic [3:0] RegK       = 4'd8;
    localparam logic [3:0] RegCount   = 4'd9;
    localparam logic [3:0] RegMar     = 4'd10;

    localparam logic [2:0] AluPass = 3'b000;
    localparam logic [2:0] AluAdd  = 3'b001;
    localparam logic [2:0] AluSub  = 3'b010;
    localparam logic [2:0] AluMul  = 3'b011;
    localparam logic [2:0] AluInc  = 3'b100;
    localparam logic [2:0] AluDec  = 3'b101;

    // Bit positions inside the 12-wide read/write strobe vectors.
    localparam int unsigned NumStb     = 12;
    localparam int unsigned StbMdr     = 0;
    localparam int unsigned StbAc      = 1;
    localparam int unsigned StbL       = 2;
    localparam int unsigned StbX       = 3;
    localparam int unsigned StbCenterP = 4;
    localparam int unsigned StbJ       = 5;
    localparam int unsigned StbMar     = 6;
    localparam int unsigned StbT       = 7;
    localparam int unsigned StbH       = 8;
    localparam int unsigned StbW       = 9;
    localparam int unsigned StbK       = 10;
    localparam int unsigned StbCount   = 11;

    typedef enum logic [4:0] {
        StFetch1, StFetch2, StDecode,
        StLdac1, StLdac2, StLdac3,
        StStac1, StStac2,
        StMvac, StMvr, StAdd, StSub, StMul,
        StIncac, StDecac, StClac, StLdi, StJump, StHalt
    } state_e;

    function automatic logic reg_code_valid(input logic [3:0] code);
        return code <= RegMar;
    endfunction

endpackage

// File: rtl/proc_controller_if.sv
// Controller <-> datapath/memory strobe bundle; master is the control unit.
interface proc_controller_if;
    logic        neg_flag;
    logic [23:0] IR;

    logic IRAM_read, IR_write, IR_read, PC_inc, PC_write;
    logic DRAM_read, DRAM_write;
    logic MDR_read, MDR_write, AC_read, AC_write, L_read, L_write;
    logic X_read, X_write, CenterP_read, CenterP_write, J_read, J_write;
    logic MAR_read, MAR_write, T_read, T_write, H_read, H_write;
    logic W_read, W_write, K_read, K_write, Count_read, Count_write;
    logic AC_reset, ALU_MUX;
    logic [2:0] ALU_op, MUX;

    modport master (
        input  neg_flag, IR,
        output IRAM_read, IR_write, IR_read, PC_inc, PC_write, DRAM_read, DRAM_write,
        output MDR_read, MDR_write, AC_read, AC_write, L_read, L_write,
        output X_read, X_write, CenterP_read, CenterP_write, J_read, J_write,
        output MAR_read, MAR_write, T_read, T_write, H_read, H_write,
        output W_read, W_write, K_read, K_write, Count_read, Count_write,
        output AC_reset, ALU_MUX, ALU_op, MUX
    );

    modport slave (
        output neg_flag, IR,
        input  IRAM_read, IR_write, IR_read, PC_inc, PC_write, DRAM_read, DRAM_write,
        input  MDR_read, MDR_write, AC_read, AC_write, L_read, L_write,
        input  X_read, X_write, CenterP_read, CenterP_write, J_read, J_write,
        input  MAR_read, MAR_write, T_read, T_write, H_read, H_write,
        input  W_read, W_write, K_read, K_write, Count_read, Count_write,
        input  AC_reset, ALU_MUX, ALU_op, MUX
    );
endinterface

// File: rtl/ctrl_reg_decode.sv
// Expands a register code plus read/write enables into per-register bus strobes.
module ctrl_reg_decode
    import ctrl_pkg::*;
(
    input  logic [3:0]        reg_code,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic              ac_rd,
    input  logic              ac_wr,
    output logic [NumStb-1:0] rd_stb,
    output logic [NumStb-1:0] wr_stb
);

    logic [NumStb-1:0] sel;

    always_comb begin
        sel = '0;
        unique case (reg_code)
            RegMdr:     sel[StbMdr]     = 1'b1;
            RegL:       sel[StbL]       = 1'b1;
            RegX:       sel[StbX]       = 1'b1;
            RegCenterP: sel[StbCenterP] = 1'b1;
            RegJ:       sel[StbJ]       = 1'b1;
            RegT:       sel[StbT]       = 1'b1;
            RegH:       sel[StbH]       = 1'b1;
            RegW:       sel[StbW]       = 1'b1;
            RegK:       sel[StbK]       = 1'b1;
            RegCount:   sel[StbCount]   = 1'b1;
            RegMar:     sel[StbMar]     = 1'b1;
            default:    ;
        endcase
        rd_stb        = rd_en ? sel : '0;
        wr_stb        = wr_en ? sel : '0;
        rd_stb[StbAc] = ac_rd;
        wr_stb[StbAc] = ac_wr;
    end

endmodule

// File: rtl/proc_controller.sv
// Multi-cycle Moore control unit: fetch, decode, and one-cycle datapath strobes per state.
module proc_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW = 8
) (
    input  logic              clk,
    input  logic              rst,
    proc_controller_if.master bus
);

    state_e     state_q, state_d;
    logic [3:0] reg_q, reg_d;
    logic [OPW-1:0] opcode;
    logic       unused_ir;

    logic       iram_read, ir_write, ir_read, pc_inc, pc_write;
    logic       dram_read, dram_write, ac_reset, alu_mux;
    logic [2:0] alu_op, mux;
    logic [3:0] dec_code;
    logic       rd_en, wr_en, ac_rd, ac_wr;
    logic [NumStb-1:0] rd_stb, wr_stb;

    assign opcode    = bus.IR[23 -: OPW];
    assign unused_ir = ^bus.IR[15:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch1;
            reg_q   <= '0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
        end
    end

    // Register code is latched at decode so execute outputs depend on state only.
    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        unique case (state_q)
            StFetch1: state_d = StFetch2;
            StFetch2: state_d = StDecode;
            StDecode: begin
                reg_d = bus.IR[3:0];
                unique case (opcode)
                    OpNop:   state_d = StFetch1;
                    OpLdac:  state_d = StLdac1;
                    OpStac:  state_d = StStac1;
                    OpMvac:  state_d = reg_code_valid(bus.IR[3:0]) ? StMvac : StFetch1;
                    OpMvr:   state_d = reg_code_valid(bus.IR[3:0]) ? StMvr : StFetch1;
                    OpAdd:   state_d = reg_code_valid(bus.IR[3:0]) ? StAdd : StFetch1;
                    OpSub:   state_d = reg_code_valid(bus.IR[3:0]) ? StSub : StFetch1;
                    OpMul:   state_d = reg_code_valid(bus.IR[3:0]) ? StMul : StFetch1;
                    OpIncac: state_d = StIncac;
                    OpDecac: state_d = StDecac;
                    OpClac:  state_d = StClac;
                    OpLdi:   state_d = StLdi;
                    OpJump:  state_d = StJump;
                    OpJmpn:  state_d = bus.neg_flag ? StJump : StFetch1;
                    OpEndop: state_d = StHalt;
                    default: state_d = StFetch1;
                endcase
            end
            StLdac1: state_d = StLdac2;
            StLdac2: state_d = StLdac3;
            StStac1: state_d = StStac2;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch1;
        endcase
    end

    always_comb begin
        iram_read  = 1'b0;
        ir_write   = 1'b0;
        ir_read    = 1'b0;
        pc_inc     = 1'b0;
        pc_write   = 1'b0;
        dram_read  = 1'b0;
        dram_write = 1'b0;
        ac_reset   = 1'b0;
        alu_mux    = 1'b0;
        alu_op     = AluPass;
        mux        = 3'b000;
        dec_code   = reg_q;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        ac_rd      = 1'b0;
        ac_wr      = 1'b0;
        // Everything stays quiet while reset is held, including the FETCH1 strobe.
        if (!rst) begin
            unique case (state_q)
                StFetch1: iram_read = 1'b1;
                StFetch2: begin
                    iram_read = 1'b1;
                    ir_write  = 1'b1;
                    pc_inc    = 1'b1;
                end
                StLdac1: dram_read = 1'b1;
                StLdac2: begin
                    dram_read = 1'b1;
                    dec_code  = RegMdr;
                    wr_en     = 1'b1;
                end
                StLdac3: begin
                    dec_code = RegMdr;
                    rd_en    = 1'b1;
                    ac_wr    = 1'b1;
                end
                StStac1: begin
                    ac_rd    = 1'b1;
                    dec_code = RegMdr;
                    wr_en    = 1'b1;
                end
                StStac2: begin
                    dec_code   = RegMdr;
                    rd_en      = 1'b1;
                    dram_write = 1'b1;
                end
                StMvac: begin
                    ac_rd = 1'b1;
                    wr_en = 1'b1;
                end
                StMvr, StAdd, StSub, StMul: begin
                    rd_en = 1'b1;
                    ac_wr = 1'b1;
                    mux   = reg_q[2:0];
                    if (state_q == StAdd) alu_op = AluAdd;
                    if (state_q == StSub) alu_op = AluSub;
                    if (state_q == StMul) alu_op = AluMul;
                end
                StIncac: begin
                    ac_wr  = 1'b1;
                    alu_op = AluInc;
                end
                StDecac: begin
                    ac_wr  = 1'b1;
                    alu_op = AluDec;
                end
                StClac: ac_reset = 1'b1;
                StLdi: begin
                    ir_read = 1'b1;
                    ac_wr   = 1'b1;
                    alu_mux = 1'b1;
                end
                StJump: begin
                    ir_read  = 1'b1;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    ctrl_reg_decode u_reg_decode (
        .reg_code (dec_code),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .ac_rd    (ac_rd),
        .ac_wr    (ac_wr),
        .rd_stb   (rd_stb),
        .wr_stb   (wr_stb)
    );

    assign bus.IRAM_read     = iram_read;
    assign bus.IR_write      = ir_write;
    assign bus.IR_read       = ir_read;
    assign bus.PC_inc        = pc_inc;
    assign bus.PC_write      = pc_write;
    assign bus.DRAM_read     = dram_read;
    assign bus.DRAM_write    = dram_write;
    assign bus.AC_reset      = ac_reset;
    assign bus.ALU_MUX       = alu_mux;
    assign bus.ALU_op        = alu_op;
    assign bus.MUX           = mux;

    assign bus.MDR_read      = rd_stb[StbMdr];
    assign bus.AC_read       = rd_stb[StbAc];
    assign bus.L_read        = rd_stb[StbL];
    assign bus.X_read        = rd_stb[StbX];
    assign bus.CenterP_read  = rd_stb[StbCenterP];
    assign bus.J_read        = rd_stb[StbJ];
    assign bus.MAR_read      = rd_stb[StbMar];
    assign bus.T_read        = rd_stb[StbT];
    assign bus.H_read        = rd_stb[StbH];
    assign bus.W_read        = rd_stb[StbW];
    assign bus.K_read        = rd_stb[StbK];
    assign bus.Count_read    = rd_stb[StbCount];

    assign bus.MDR_write     = wr_stb[StbMdr];
    assign bus.AC_write      = wr_stb[StbAc];
    assign bus.L_write       = wr_stb[StbL];
    assign bus.X_write       = wr_stb[StbX];
    assign bus.CenterP_write = wr_stb[StbCenterP];
    assign bus.J_write       = wr_stb[StbJ];
    assign bus.MAR_write     = wr_stb[StbMar];
    assign bus.T_write       = wr_stb[StbT];
    assign bus.H_write       = wr_stb[StbH];
    assign bus.W_write       = wr_stb[StbW];
    assign bus.K_write       = wr_stb[StbK];
    assign bus.Count_write   = wr_stb[StbCount];

endmodule

// File: tb/tb_proc_controller.sv
// Self-checking bench: per-instruction expected strobe sequences from an opcode table model.
module tb_proc_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    proc_controller_if bus ();

    proc_controller #(.OPW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // rd/wr index = register code 0..10 (MDR,L,X,CenterP,J,T,H,W,K,Count,MAR), 11 = AC.
    typedef struct packed {
        logic        iram_read, ir_write, ir_read, pc_inc, pc_write;
        logic        dram_read, dram_write, ac_reset, alu_mux;
        logic [2:0]  alu_op;
        logic [2:0]  mux;
        logic [11:0] rd;
        logic [11:0] wr;
    } outs_t;

    localparam int AC = 11;

    int    n_checks = 0;
    int    n_fails  = 0;
    outs_t exp_q[$];

    function automatic outs_t snap();
        outs_t o;
        o = '0;
        o.iram_read  = bus.IRAM_read;
        o.ir_write   = bus.IR_write;
        o.ir_read    = bus.IR_read;
        o.pc_inc     = bus.PC_inc;
        o.pc_write   = bus.PC_write;
        o.dram_read  = bus.DRAM_read;
        o.dram_write = bus.DRAM_write;
        o.ac_reset   = bus.AC_reset;
        o.alu_mux    = bus.ALU_MUX;
        o.alu_op     = bus.ALU_op;
        o.mux        = bus.MUX;
        o.rd = {bus.AC_read, bus.MAR_read, bus.Count_read, bus.K_read, bus.W_read, bus.H_read,
                bus.T_read, bus.J_read, bus.CenterP_read, bus.X_read, bus.L_read, bus.MDR_read};
        o.wr = {bus.AC_write, bus.MAR_write, bus.Count_write, bus.K_write, bus.W_write,
                bus.H_write, bus.T_write, bus.J_write, bus.CenterP_write, bus.X_write,
                bus.L_write, bus.MDR_write};
        return o;
    endfunction

    task automatic check(input string tag, input outs_t expv);
        outs_t obs;
        obs = snap();
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic outs_t fetch1_vec();
        outs_t e;
        e = '0;
        e.iram_read = 1'b1;
        return e;
    endfunction

    // Expected output for every cycle from FETCH1 up to (not including) the next FETCH1.
    function automatic void model(input logic [23:0] ir, input logic neg);
        outs_t      e;
        logic [7:0] op;
        int         r;
        bit         ok;
        op = ir[23:16];
        r  = int'(ir[3:0]);
        ok = (r <= 10);
        exp_q.delete();
        e = fetch1_vec();
        exp_q.push_back(e);
        e.ir_write = 1'b1;
        e.pc_inc   = 1'b1;
        exp_q.push_back(e);
        e = '0;
        exp_q.push_back(e);
        case (op)
            8'h01: begin
                e.dram_read = 1'b1;
                exp_q.push_back(e);
                e.wr[0] = 1'b1;
                exp_q.push_back(e);
                e = '0;
                e.rd[0]  = 1'b1;
                e.wr[AC] = 1'b1;
                exp_q.push_back(e);
            end
            8'h02: begin
                e.rd[AC] = 1'b1;
                e.wr[0]  = 1'b1;
                exp_q.push_back(e);
                e = '0;
                e.rd[0]      = 1'b1;
                e.dram_write = 1'b1;
                exp_q.push_back(e);
            end
            8'h03: if (ok) begin
                e.rd[AC] = 1'b1;
                e.wr[r]  = 1'b1;
                exp_q.push_back(e);
            end
            8'h04, 8'h05, 8'h06, 8'h07: if (ok) begin
                e.rd[r]  = 1'b1;
                e.wr[AC] = 1'b1;
                e.mux    = ir[2:0];
                e.alu_op = (op == 8'h04) ? 3'd0 : 3'(op - 8'h04);
                exp_q.push_back(e);
            end
            8'h08, 8'h09: begin
                e.wr[AC] = 1'b1;
                e.alu_op = (op == 8'h08) ? 3'd4 : 3'd5;
                exp_q.push_back(e);
            end
            8'h0A: begin
                e.ac_reset = 1'b1;
                exp_q.push_back(e);
            end
            8'h0B: begin
                e.ir_read  = 1'b1;
                e.wr[AC]   = 1'b1;
                e.alu_mux  = 1'b1;
                exp_q.push_back(e);
            end
            8'h0C, 8'h0D: if (op == 8'h0C || neg) begin
                e.ir_read  = 1'b1;
                e.pc_write = 1'b1;
                exp_q.push_back(e);
            end
            8'h0E: for (int i = 0; i < 22; i++) exp_q.push_back(e);
            default: ;
        endcase
    endfunction

    // Entered #1 after a posedge with the DUT in FETCH1; leaves it the same way.
    task automatic run_instr(input string tag, input logic [23:0] ir, input logic neg,
                             input int limit);
        int n;
        bus.IR       = ir;
        bus.neg_flag = neg;
        model(ir, neg);
        n = (limit > 0 && limit < exp_q.size()) ? limit : exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s.c%0d", tag, i + 1), exp_q[i]);
            if (i < n - 1 || limit == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        logic [23:0] ir;
        logic [7:0]  op;
        int          pick;

        bus.IR       = '0;
        bus.neg_flag = 1'b0;
        rst          = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", '0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        run_instr("ldac",     24'h010000, 1'b0, 0);
        run_instr("add_x",    24'h050002, 1'b0, 0);
        run_instr("jmpn_t",   24'h0D0040, 1'b1, 0);
        run_instr("jmpn_f",   24'h0D0040, 1'b0, 0);
        run_instr("mvac_mar", 24'h03000A, 1'b0, 0);
        run_instr("ldi",      24'h0B00FF, 1'b0, 0);
        run_instr("op_ff",    24'hFF0000, 1'b1, 0);
        run_instr("stac",     24'h020000, 1'b0, 0);
        run_instr("mvr_k",    24'h040008, 1'b0, 0);
        run_instr("sub_cnt",  24'h060009, 1'b0, 0);
        run_instr("mul_w",    24'h070007, 1'b0, 0);
        run_instr("incac",    24'h080000, 1'b0, 0);
        run_instr("decac",    24'h090000, 1'b0, 0);
        run_instr("clac",     24'h0A0000, 1'b0, 0);
        run_instr("jump",     24'h0C1234, 1'b0, 0);
        run_instr("add_bad",  24'h05000C, 1'b0, 0);

        // Reset mid-LDAC during L2: outputs drop without waiting for a clock.
        run_instr("ldac_pre", 24'h010000, 1'b0, 5);
        #1 rst = 1'b1;
        #1 check("rst_async", '0);
        @(posedge clk);
        #1 check("rst_hold", '0);
        rst = 1'b0;
        run_instr("ldac_post", 24'h010000, 1'b0, 0);

        // ENDOP parks the controller until reset.
        run_instr("endop", 24'h0E0000, 1'b0, 0);
        bus.IR       = 24'h010000;
        bus.neg_flag = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("halt_hold", '0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("halt_rst", '0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 80; k++) begin
            pick = $urandom_range(0, 19);
            op   = (pick < 14) ? 8'(pick) : 8'($urandom_range(0, 255));
            if (op == 8'h0E) op = 8'hFF;
            ir = {op, 16'($urandom())};
            run_instr($sformatf("rnd%0d_%h", k, ir), ir, 1'($urandom_range(0, 1)), 0);
        end

        @(negedge clk);
        check("final_fetch1", fetch1_vec());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
